// File: rtl/clic_hart_model.sv
// Cycle-level model of a RISC-V hart's CLIC trap/CSR behaviour: interrupt acceptance,
// trap entry with modelled latency, and a queued NOP/CSRW/MRET/SRET instruction stream.
//
// state | meaning
// RUN   | accept interrupts or pop/execute one queued instruction per cycle
// STALL | trap-entry latency; counts down, pulses trap_o on the last cycle
module clic_hart_model #(
  parameter int XLEN     = 64,
  parameter int MODES    = 3,
  parameter int IQ_DEPTH = 4,
  parameter int TRAP_LAT = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               irq_valid_i,
  input  logic [11:0]        irq_id_i,
  input  logic [7:0]         irq_level_i,
  input  logic [1:0]         irq_priv_i,
  input  logic               irq_shv_i,
  output logic               irq_ready_o,
  input  logic               instr_valid_i,
  input  logic [16+XLEN-1:0] instr_i,
  output logic               instr_ready_o,
  output logic [1:0]         priv_o,
  output logic [XLEN-1:0]    mstatus_o,
  output logic [XLEN-1:0]    mcause_o,
  output logic [XLEN-1:0]    scause_o,
  output logic [31:0]        mintstatus_o,
  output logic [7:0]         mintthresh_o,
  output logic [7:0]         sintthresh_o,
  output logic               trap_o,
  output logic               err_valid_o,
  output logic [3:0]         err_code_o
);

  localparam int QW = 14 + XLEN;
  localparam int PW = $clog2(IQ_DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = $clog2(TRAP_LAT + 1);

  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] OP_CSRW = 2'd1;
  localparam logic [1:0] OP_MRET = 2'd2;
  localparam logic [1:0] OP_SRET = 2'd3;

  localparam int SIE  = 1;
  localparam int MIE  = 3;
  localparam int SPIE = 5;
  localparam int MPIE = 7;
  localparam int SPP  = 8;

  localparam logic [XLEN-1:0] M_FIELDS = XLEN'(32'h0000_1888);
  localparam logic [XLEN-1:0] S_FIELDS = XLEN'(32'h0000_0122);
  localparam logic [XLEN-1:0] MSTATUS_WMASK = M_FIELDS | ((MODES == 3) ? S_FIELDS : '0);
  localparam logic [XLEN-1:0] SSTATUS_WMASK = XLEN'(32'h000C_6122);
  localparam logic [1:0] MODE_FLOOR = (MODES == 1) ? 2'b11 : 2'b00;

  typedef enum logic {RUN, STALL} state_t;

  function automatic logic mode_impl(input logic [1:0] m);
    case (m)
      2'b11:   mode_impl = 1'b1;
      2'b01:   mode_impl = (MODES == 3);
      2'b00:   mode_impl = (MODES >= 2);
      default: mode_impl = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] legal_mode(input logic [1:0] m);
    legal_mode = mode_impl(m) ? m : MODE_FLOOR;
  endfunction

  state_t            state_q, state_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic [1:0]        priv_q, priv_d;
  logic [XLEN-1:0]   mstatus_q, mstatus_d, mcause_q, mcause_d, scause_q, scause_d;
  logic [7:0]        mil_q, mil_d, sil_q, sil_d;
  logic [7:0]        mthr_q, mthr_d, sthr_q, sthr_d;

  logic [QW-1:0]     iq_mem [IQ_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              full, empty, push, pop;
  logic [QW-1:0]     head;
  logic [1:0]        head_op;
  logic [11:0]       head_addr;
  logic [XLEN-1:0]   head_data;
  logic              unused_pad;

  assign full          = (count_q == CW'(IQ_DEPTH));
  assign empty         = (count_q == '0);
  assign push          = instr_valid_i && !full;
  assign instr_ready_o = !full;
  assign head          = iq_mem[rd_ptr_q];
  assign head_op       = head[XLEN+13:XLEN+12];
  assign head_addr     = head[XLEN+11:XLEN];
  assign head_data     = head[XLEN-1:0];
  assign unused_pad    = ^instr_i[XLEN+15:XLEN+14];

  // Interrupt eligibility; x selects the M or S context of the target mode.
  logic       x_m, x_ie, irq_take;
  logic [7:0] x_il, x_th, x_max;

  assign x_m   = (irq_priv_i == 2'b11);
  assign x_ie  = x_m ? mstatus_q[MIE] : ((irq_priv_i == 2'b01) ? mstatus_q[SIE] : 1'b0);
  assign x_il  = x_m ? mil_q  : sil_q;
  assign x_th  = x_m ? mthr_q : sthr_q;
  assign x_max = (x_il > x_th) ? x_il : x_th;
  assign irq_take = irq_valid_i && mode_impl(irq_priv_i) &&
                    ((irq_priv_i > priv_q) ||
                     ((irq_priv_i == priv_q) && x_ie && (irq_level_i > x_max)));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    priv_d      = priv_q;
    mstatus_d   = mstatus_q;
    mcause_d    = mcause_q;
    scause_d    = scause_q;
    mil_d       = mil_q;
    sil_d       = sil_q;
    mthr_d      = mthr_q;
    sthr_d      = sthr_q;
    pop         = 1'b0;
    irq_ready_o = 1'b0;
    trap_o      = 1'b0;
    err_valid_o = 1'b0;
    err_code_o  = 4'd0;
    case (state_q)
      RUN: begin
        if (irq_take) begin
          irq_ready_o = 1'b1;
          state_d     = STALL;
          cnt_d       = LW'(TRAP_LAT);
          if (x_m) begin
            mcause_d          = '0;
            mcause_d[XLEN-1]  = 1'b1;
            mcause_d[30]      = irq_shv_i;
            mcause_d[29:28]   = priv_q;
            mcause_d[27]      = mstatus_q[MIE];
            mcause_d[23:16]   = mil_q;
            mcause_d[11:0]    = irq_id_i;
            mstatus_d[MPIE]   = mstatus_q[MIE];
            mstatus_d[MIE]    = 1'b0;
            mstatus_d[12:11]  = priv_q;
            mil_d             = irq_level_i;
            priv_d            = 2'b11;
          end else begin
            scause_d          = '0;
            scause_d[XLEN-1]  = 1'b1;
            scause_d[30]      = irq_shv_i;
            scause_d[28]      = priv_q[0];
            scause_d[27]      = mstatus_q[SIE];
            scause_d[23:16]   = sil_q;
            scause_d[11:0]    = irq_id_i;
            mstatus_d[SPIE]   = mstatus_q[SIE];
            mstatus_d[SIE]    = 1'b0;
            mstatus_d[SPP]    = priv_q[0];
            sil_d             = irq_level_i;
            priv_d            = 2'b01;
          end
        end else if (!empty) begin
          pop = 1'b1;
          case (head_op)
            OP_CSRW: begin
              if (head_addr[9:8] > priv_q) begin
                err_valid_o = 1'b1;
                err_code_o  = 4'd0;
              end else begin
                case (head_addr)
                  12'h300: begin
                    mstatus_d = (mstatus_q & ~MSTATUS_WMASK) | (head_data & MSTATUS_WMASK);
                    mstatus_d[12:11] = legal_mode(head_data[12:11]);
                  end
                  12'h347: mthr_d   = head_data[7:0];
                  12'h342: mcause_d = head_data;
                  12'h305, 12'h341, 12'h307: ;
                  12'h100, 12'h147, 12'h142, 12'h105, 12'h141, 12'h107: begin
                    if (MODES != 3) begin
                      err_valid_o = 1'b1;
                      err_code_o  = 4'd9;
                    end else if (head_addr == 12'h100) begin
                      mstatus_d = (mstatus_q & ~SSTATUS_WMASK) | (head_data & SSTATUS_WMASK);
                    end else if (head_addr == 12'h147) begin
                      sthr_d = head_data[7:0];
                    end else if (head_addr == 12'h142) begin
                      scause_d = head_data;
                    end
                  end
                  default: begin
                    err_valid_o = 1'b1;
                    err_code_o  = 4'd9;
                  end
                endcase
              end
            end
            OP_MRET: begin
              if (priv_q != 2'b11) begin
                err_valid_o = 1'b1;
                err_code_o  = 4'd1;
              end else begin
                priv_d           = legal_mode(mstatus_q[12:11]);
                mstatus_d[MIE]   = mstatus_q[MPIE];
                mstatus_d[MPIE]  = 1'b1;
                mstatus_d[12:11] = MODE_FLOOR;
                mil_d            = mcause_q[23:16];
              end
            end
            OP_SRET: begin
              if ((MODES != 3) || (priv_q == 2'b00)) begin
                err_valid_o = 1'b1;
                err_code_o  = 4'd2;
              end else begin
                priv_d          = mstatus_q[SPP] ? 2'b01 : 2'b00;
                mstatus_d[SIE]  = mstatus_q[SPIE];
                mstatus_d[SPIE] = 1'b1;
                mstatus_d[SPP]  = 1'b0;
                sil_d           = scause_q[23:16];
              end
            end
            default: ;
          endcase
        end
      end
      STALL: begin
        cnt_d = cnt_q - LW'(1);
        if (cnt_q == LW'(1)) begin
          trap_o  = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      priv_q    <= 2'b11;
      mstatus_q <= '0;
      mcause_q  <= '0;
      scause_q  <= '0;
      mil_q     <= '0;
      sil_q     <= '0;
      mthr_q    <= '0;
      sthr_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      priv_q    <= priv_d;
      mstatus_q <= mstatus_d;
      mcause_q  <= mcause_d;
      scause_q  <= scause_d;
      mil_q     <= mil_d;
      sil_q     <= sil_d;
      mthr_q    <= mthr_d;
      sthr_q    <= sthr_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q   <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) iq_mem[wr_ptr_q] <= instr_i[QW-1:0];
  end

  assign priv_o       = priv_q;
  assign mstatus_o    = mstatus_q;
  assign mcause_o     = mcause_q;
  assign scause_o     = (MODES == 3) ? scause_q : '0;
  assign mintstatus_o = {mil_q, 8'h00, sil_q, 8'h00};
  assign mintthresh_o = mthr_q;
  assign sintthresh_o = sthr_q;

endmodule

// File: tb/tb_clic_hart_model.sv
// Directed bench: a default hart (XLEN=64, M+S+U) and a small one (XLEN=32, M+U).
module tb_clic_hart_model;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        irq_valid, irq_shv, irq_ready;
  logic [11:0] irq_id;
  logic [7:0]  irq_level;
  logic [1:0]  irq_priv;
  logic        instr_valid, instr_ready;
  logic [79:0] instr;
  logic [1:0]  priv;
  logic [63:0] mstatus, mcause, scause;
  logic [31:0] mintstatus;
  logic [7:0]  mintthresh, sintthresh;
  logic        trap, err_valid;
  logic [3:0]  err_code;

  logic        irq_valid2, irq_shv2, irq_ready2;
  logic [11:0] irq_id2;
  logic [7:0]  irq_level2;
  logic [1:0]  irq_priv2;
  logic        instr_valid2, instr_ready2;
  logic [47:0] instr2;
  logic [1:0]  priv2;
  logic [31:0] mstatus2, mcause2, scause2, mintstatus2;
  logic [7:0]  mintthresh2, sintthresh2;
  logic        trap2, err_valid2;
  logic [3:0]  err_code2;

  clic_hart_model dut (
    .clk_i(clk), .rst_ni(rst_n),
    .irq_valid_i(irq_valid), .irq_id_i(irq_id), .irq_level_i(irq_level),
    .irq_priv_i(irq_priv), .irq_shv_i(irq_shv), .irq_ready_o(irq_ready),
    .instr_valid_i(instr_valid), .instr_i(instr), .instr_ready_o(instr_ready),
    .priv_o(priv), .mstatus_o(mstatus), .mcause_o(mcause), .scause_o(scause),
    .mintstatus_o(mintstatus), .mintthresh_o(mintthresh), .sintthresh_o(sintthresh),
    .trap_o(trap), .err_valid_o(err_valid), .err_code_o(err_code)
  );

  clic_hart_model #(.XLEN(32), .MODES(2), .IQ_DEPTH(4), .TRAP_LAT(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n),
    .irq_valid_i(irq_valid2), .irq_id_i(irq_id2), .irq_level_i(irq_level2),
    .irq_priv_i(irq_priv2), .irq_shv_i(irq_shv2), .irq_ready_o(irq_ready2),
    .instr_valid_i(instr_valid2), .instr_i(instr2), .instr_ready_o(instr_ready2),
    .priv_o(priv2), .mstatus_o(mstatus2), .mcause_o(mcause2), .scause_o(scause2),
    .mintstatus_o(mintstatus2), .mintthresh_o(mintthresh2), .sintthresh_o(sintthresh2),
    .trap_o(trap2), .err_valid_o(err_valid2), .err_code_o(err_code2)
  );

  localparam logic [1:0] NOP = 2'd0, CSRW = 2'd1, MRET = 2'd2, SRET = 2'd3;

  int total = 0;
  int bad = 0;
  int n_err = 0, n_err2 = 0, n_trap = 0;
  logic [3:0] last_err = 4'hF, last_err2 = 4'hF;

  // Pulse monitors, sampled just before each active edge.
  always @(posedge clk) begin
    if (err_valid)  begin n_err  = n_err + 1;  last_err  = err_code;  end
    if (err_valid2) begin n_err2 = n_err2 + 1; last_err2 = err_code2; end
    if (trap) n_trap = n_trap + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exec(input logic [1:0] op, input logic [11:0] a, input logic [63:0] d);
    instr_valid = 1'b1;
    instr = {2'b00, op, a, d};
    tick(1);
    instr_valid = 1'b0;
    tick(1);
  endtask

  task automatic exec2(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    instr_valid2 = 1'b1;
    instr2 = {2'b00, op, a, d};
    tick(1);
    instr_valid2 = 1'b0;
    tick(1);
  endtask

  task automatic set_irq(input logic [1:0] p, input logic [7:0] l, input logic [11:0] id, input logic s);
    irq_valid = 1'b1; irq_priv = p; irq_level = l; irq_id = id; irq_shv = s;
  endtask

  int e0, t0;

  initial begin
    rst_n = 1'b0;
    irq_valid = 0; irq_id = 0; irq_level = 0; irq_priv = 0; irq_shv = 0;
    instr_valid = 0; instr = '0;
    irq_valid2 = 0; irq_id2 = 0; irq_level2 = 0; irq_priv2 = 0; irq_shv2 = 0;
    instr_valid2 = 0; instr2 = '0;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    chk("rst_priv", 64'(priv), 64'h3);
    chk("rst_mstatus", mstatus, 64'h0);
    chk("rst_mcause", mcause, 64'h0);
    chk("rst_scause", scause, 64'h0);
    chk("rst_mintstatus", 64'(mintstatus), 64'h0);
    chk("rst_thresh", 64'({mintthresh, sintthresh}), 64'h0);
    chk("rst_ready", 64'(instr_ready), 64'h1);
    chk("rst_pulses", 64'({irq_ready, trap, err_valid}), 64'h0);

    exec(CSRW, 12'h300, 64'h8);
    chk("wr_mstatus_mie", mstatus, 64'h8);
    exec(CSRW, 12'h347, 64'h10);
    chk("wr_mintthresh", 64'(mintthresh), 64'h10);

    set_irq(2'b11, 8'h10, 12'd11, 1'b0);
    @(negedge clk);
    chk("irq_at_thresh_rejected", 64'(irq_ready), 64'h0);
    tick(1);

    set_irq(2'b11, 8'h20, 12'd11, 1'b0);
    @(negedge clk);
    chk("irq_m_ready", 64'(irq_ready), 64'h1);
    tick(1);
    irq_valid = 1'b0;
    @(negedge clk);
    chk("stall_no_trap_yet", 64'(trap), 64'h0);
    tick(1);
    @(negedge clk);
    chk("trap_after_lat", 64'(trap), 64'h1);
    tick(1);
    chk("m_trap_mcause", mcause, 64'h8000_0000_3800_000B);
    chk("m_trap_mintstatus", 64'(mintstatus), 64'h2000_0000);
    chk("m_trap_mstatus", mstatus, 64'h1880);

    exec(CSRW, 12'h300, 64'h2);
    chk("wr_mstatus_sie", mstatus, 64'h2);
    exec(MRET, 12'h0, 64'h0);
    chk("mret_priv_u", 64'(priv), 64'h0);
    chk("mret_mstatus", mstatus, 64'h82);

    set_irq(2'b10, 8'hFF, 12'd1, 1'b0);
    @(negedge clk);
    chk("irq_priv10_ignored", 64'(irq_ready), 64'h0);
    tick(1);
    irq_valid = 1'b0;

    e0 = n_err;
    exec(CSRW, 12'h300, 64'hFFFF);
    chk("u_csrw_err_cnt", 64'(n_err - e0), 64'h1);
    chk("u_csrw_err_code", 64'(last_err), 64'h0);
    chk("u_csrw_mstatus_kept", mstatus, 64'h82);
    exec(MRET, 12'h0, 64'h0);
    chk("u_mret_err_code", 64'(last_err), 64'h1);
    chk("u_mret_err_cnt", 64'(n_err - e0), 64'h2);

    t0 = n_trap;
    set_irq(2'b01, 8'h40, 12'd7, 1'b1);
    @(negedge clk);
    chk("irq_s_ready", 64'(irq_ready), 64'h1);
    tick(1);
    irq_valid = 1'b0;
    tick(2);
    chk("s_trap_pulse", 64'(n_trap - t0), 64'h1);
    chk("s_trap_priv", 64'(priv), 64'h1);
    chk("s_trap_scause", scause, 64'h8000_0000_4800_0007);
    chk("s_trap_mstatus", mstatus, 64'hA0);
    chk("s_trap_mintstatus", 64'(mintstatus), 64'h4000);
    exec(SRET, 12'h0, 64'h0);
    chk("sret_priv", 64'(priv), 64'h0);
    chk("sret_mstatus", mstatus, 64'hA2);
    chk("sret_sil", 64'(mintstatus), 64'h0);

    // Queued CSRW at the head when an interrupt arrives; NOPs pushed through the stall.
    e0 = n_err;
    instr_valid = 1'b1;
    instr = {2'b00, CSRW, 12'h347, 64'h33};
    tick(1);
    instr = {2'b00, NOP, 12'h0, 64'h0};
    set_irq(2'b11, 8'h05, 12'd3, 1'b0);
    @(negedge clk);
    chk("q_irq_first", 64'(irq_ready), 64'h1);
    tick(1);
    irq_valid = 1'b0;
    @(negedge clk);
    chk("q_ready_stall", 64'(instr_ready), 64'h1);
    tick(1);
    @(negedge clk);
    chk("q_trap", 64'(trap), 64'h1);
    chk("q_csrw_deferred", 64'(mintthresh), 64'h10);
    tick(1);
    @(negedge clk);
    chk("q_full", 64'(instr_ready), 64'h0);
    tick(1);
    chk("q_csrw_after_stall", 64'(mintthresh), 64'h33);
    tick(1);
    instr_valid = 1'b0;
    tick(6);
    chk("q_drained", 64'(instr_ready), 64'h1);
    chk("q_no_err", 64'(n_err - e0), 64'h0);
    chk("q_mcause", mcause, 64'h8000_0000_0000_0003);
    chk("q_mstatus", mstatus, 64'h22);
    chk("q_mintstatus", 64'(mintstatus), 64'h0500_0000);
    chk("q_priv", 64'(priv), 64'h3);

    exec(CSRW, 12'h300, 64'h1000);
    chk("mpp_legalize", mstatus, 64'h0);
    e0 = n_err;
    exec(CSRW, 12'h7C0, 64'h1);
    chk("undef_csr_cnt", 64'(n_err - e0), 64'h1);
    chk("undef_csr_code", 64'(last_err), 64'h9);
    exec(CSRW, 12'h342, 64'h1234);
    chk("wr_mcause", mcause, 64'h1234);

    // Small hart: M+U, XLEN=32.
    exec2(MRET, 12'h0, 32'h0);
    chk("h2_mret_priv", 64'(priv2), 64'h0);
    e0 = n_err2;
    exec2(SRET, 12'h0, 32'h0);
    chk("h2_sret_err_cnt", 64'(n_err2 - e0), 64'h1);
    chk("h2_sret_err_code", 64'(last_err2), 64'h2);
    irq_valid2 = 1'b1; irq_priv2 = 2'b01; irq_level2 = 8'hFF; irq_id2 = 12'd2;
    @(negedge clk);
    chk("h2_s_irq_ignored", 64'(irq_ready2), 64'h0);
    tick(1);
    irq_priv2 = 2'b11; irq_level2 = 8'h01; irq_id2 = 12'd5;
    @(negedge clk);
    chk("h2_m_irq_ready", 64'(irq_ready2), 64'h1);
    tick(1);
    irq_valid2 = 1'b0;
    tick(2);
    chk("h2_mcause", 64'(mcause2), 64'h8000_0005);
    chk("h2_priv", 64'(priv2), 64'h3);
    chk("h2_scause_zero", 64'(scause2), 64'h0);

    // Reset in the middle of a trap stall: no trap pulse.
    exec(CSRW, 12'h300, 64'h8);
    t0 = n_trap;
    set_irq(2'b11, 8'h40, 12'd9, 1'b0);
    @(negedge clk);
    chk("rst_stall_irq", 64'(irq_ready), 64'h1);
    tick(1);
    irq_valid = 1'b0;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    chk("rst_stall_no_trap", 64'(n_trap - t0), 64'h0);
    chk("rst_stall_mstatus", mstatus, 64'h0);
    chk("rst_stall_priv", 64'(priv), 64'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clic_hart_model.md
Name: clic_hart_model

Overview:
- Parametrised cycle-level model of a RISC-V hart's CLIC trap and CSR behaviour. It is a successor to the flat, fixed-XLEN, M/S/U-only testbench type set.
- It sits between the CLIC interrupt output and the scoreboard, and consumes a queued stream of NOP/CSRW/MRET/SRET instructions.
- It accepts interrupts under CLIC level/threshold rules, performs trap entry/exit and claims the interrupt. It exposes architectural state and flags illegal operations.
- New over the previous generation: selectable XLEN, selectable privilege-mode set, an instruction queue and modelled trap-entry latency.

Parameters:
- XLEN, 64, register width; 32 or 64. irq/interrupt flag at bit XLEN-1; all other mcause/scause fields at fixed low bit positions.
- MODES, 3, implemented modes: 1=M only, 2=M+U, 3=M+S+U.
- IQ_DEPTH, 4, instruction queue entries (power of 2, ≥2).
- TRAP_LAT, 2, stall cycles after an interrupt is accepted (≥1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- irq_valid_i  in  1  CLIC presents an interrupt
- irq_id_i  in  12  exception code
- irq_level_i  in  8  interrupt level
- irq_priv_i  in  2  target mode (11=M, 01=S, 00=U)
- irq_shv_i  in  1  selective hardware vectoring
- irq_ready_o  out  1  claim pulse: interrupt accepted this cycle
- instr_valid_i  in  1  instruction push request
- instr_i  in  16+XLEN  {pad[1:0], op[1:0], csr_addr[11:0], data[XLEN-1:0]}
- instr_ready_o  out  1  queue not full
- priv_o  out  2  current privilege
- mstatus_o  out  XLEN  mstatus
- mcause_o  out  XLEN  mcause
- scause_o  out  XLEN  scause; 0 when MODES<3
- mintstatus_o  out  32  {mil, rsv, sil, uil}
- mintthresh_o  out  8
- sintthresh_o  out  8
- trap_o  out  1  one-cycle pulse when stall ends and the handler begins
- err_valid_o  out  1  one-cycle error pulse
- err_code_o  out  4  0 generic/privilege, 1 illegal MRET, 2 illegal SRET, 9 undefined CSR write

Behaviour:

Reset (async):
- priv_o=11; all CSRs 0; queue empty.
- irq_ready_o, trap_o and err_valid_o are 0; instr_ready_o=1.
- Reset asserted during a trap stall aborts the stall; no trap_o pulse.

Queue:
- Push when instr_valid_i && instr_ready_o.
- instr_ready_o = !full; no bypass.
- Push and pop in the same cycle are allowed.
- Pointers wrap modulo IQ_DEPTH.

FSM states: RUN, STALL.

RUN, each cycle, in priority order:
1) Interrupt acceptance, when irq_valid_i and either:
   - irq_priv_i > priv_o, or
   - irq_priv_i == priv_o && xIE set && irq_level_i > max(xil, xintthresh).
   Here x = M or S per irq_priv_i. irq_priv_i values that MODES does not implement are ignored.
   - irq_ready_o=1 this cycle.
   - CSRs update at the next edge; then go to STALL with a counter of TRAP_LAT.
   - The queue head is not popped.
2) Otherwise, if the queue is non-empty, pop and execute one instruction:
   - NOP: no effect.
   - CSRW:
     - csr_addr[9:8] > priv_o gives err 0.
     - MSTATUS writes only MIE, MPIE, MPP, SIE, SPIE, SPP. S fields are writable only if MODES=3. An MPP value naming an unimplemented mode is written as U (M if MODES=1).
     - SSTATUS writes through the S write mask (SIE, SPIE, SPP, FS, SUM, MXR).
     - MINTTHRESH, SINTTHRESH: low 8 bits.
     - MCAUSE, SCAUSE: full write.
     - MTVEC, MEPC, MTVT, STVEC, SEPC, STVT: accepted, no visible state.
     - Any other address, or S-CSRs with MODES<3, gives err 9.
   - MRET:
     - priv≠M gives err 1.
     - Otherwise: priv←MPP; MIE←MPIE; MPIE←1; MPP←U (M if MODES=1); mil←mcause.mpil.
   - SRET:
     - MODES<3 or priv==U gives err 2.
     - Otherwise: priv←SPP?S:U; SIE←SPIE; SPIE←1; SPP←0; sil←scause.spil.

Trap entry to M:
- mcause ← {irq=1, shv, mpp=priv, mpie=MIE, mpil=mil, excode=irq_id_i}.
- MPIE←MIE; MIE←0; MPP←priv; mil←irq_level_i; priv←M.

Trap entry to S (MODES=3):
- scause ← {irq=1, shv, spp=priv[0], spie=SIE, spil=sil, excode}.
- SPIE←SIE; SIE←0; SPP←priv[0]; sil←irq_level_i; priv←S.

STALL:
- Counter decrements each cycle; no instruction executes and no interrupt is accepted.
- At counter 1: trap_o=1, return to RUN.

General:
- Error instructions are popped with no state change.
- At most one error per cycle.

Test Plan:
- Reset, then idle → priv_o=11, all CSRs 0, instr_ready_o=1, outputs low.
- MODES=3, priv M, MIE=1, mintthresh=0x10; irq lvl 0x20 priv M id 11 → irq_ready_o pulse; after TRAP_LAT=2 trap_o. Then mcause_o={irq,mpie=1,mpp=11,excode=11}, mil=0x20, MIE=0.
- Same setup with irq lvl 0x10 → not accepted, irq_ready_o stays 0.
- In U mode, push CSRW MSTATUS → err 0, mstatus unchanged. MRET → err 1. SRET with MODES=2 → err 2.
- S-trap from U with lvl 0x40 then SRET → priv 00, SIE restored, sil restored to prior 0.
- IQ_DEPTH=4: push 4 NOPs during STALL → instr_ready_o=0 on 4th. A simultaneous irq and queued CSRW → trap taken first, CSRW executes after STALL. XLEN=32: mcause_o[31]=1.
